// File: rtl/hazard3_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Latency: lookup is combinational from table state; a training write is visible to lookups the following cycle.
// Backpressure: none; one lookup and one training write are accepted every cycle.
module hazard3_branch_predictor #(
    parameter int W_ADDR    = 32,
    parameter int N_ENTRIES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_vld,
    input  logic [W_ADDR-1:0] pred_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [W_ADDR-1:0] pred_target,
    input  logic              upd_vld,
    input  logic [W_ADDR-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [W_ADDR-1:0] upd_target,
    input  logic              inval
);

    // Index skips bit 0: branches are halfword aligned so compressed code can use every slot.
    localparam int K     = $clog2(N_ENTRIES);
    localparam int TAG_W = W_ADDR - K - 1;

    logic [N_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q    [N_ENTRIES];
    logic [TAG_W-1:0]     tag_d    [N_ENTRIES];
    logic [W_ADDR-2:0]    target_q [N_ENTRIES];
    logic [W_ADDR-2:0]    target_d [N_ENTRIES];
    logic [1:0]           ctr_q    [N_ENTRIES];
    logic [1:0]           ctr_d    [N_ENTRIES];

    logic [K-1:0]     pred_idx;
    logic [TAG_W-1:0] pred_tag;
    logic [K-1:0]     upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             pred_match;
    logic             upd_match;

    // Bit 0 of every address carries no information for the table.
    logic unused_bit0;
    assign unused_bit0 = ^{pred_pc[0], upd_pc[0], upd_target[0]};

    assign pred_idx = pred_pc[K:1];
    assign pred_tag = pred_pc[W_ADDR-1:K+1];
    assign upd_idx  = upd_pc[K:1];
    assign upd_tag  = upd_pc[W_ADDR-1:K+1];

    // Lookup: reads only registered state, so training never races the fetch path.
    always_comb begin
        pred_match  = pred_vld && valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
        pred_hit    = pred_match;
        pred_taken  = pred_match && ctr_q[pred_idx][1];
        pred_target = pred_match ? {target_q[pred_idx], 1'b0} : '0;
    end

    // Training: invalidate beats any same-cycle update; not-taken misses never allocate.
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        upd_match = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (inval) begin
            valid_d = '0;
        end else if (upd_vld) begin
            if (upd_match) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                    end
                    target_d[upd_idx] = upd_target[W_ADDR-1:1];
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // New entry starts weakly taken and evicts whatever aliased here.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target[W_ADDR-1:1];
                ctr_d[upd_idx]    = 2'b10;
            end
        end
    end

    // Table state; asynchronous reset empties the table and drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b00;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: tb/tb_hazard3_branch_predictor.sv
module tb_hazard3_branch_predictor;

    localparam int W = 32;
    localparam int N = 4;
    localparam int K = 2;

    logic          clk;
    logic          rst;
    logic          pred_vld;
    logic [W-1:0]  pred_pc;
    logic          pred_hit;
    logic          pred_taken;
    logic [W-1:0]  pred_target;
    logic          upd_vld;
    logic [W-1:0]  upd_pc;
    logic          upd_taken;
    logic [W-1:0]  upd_target;
    logic          inval;

    int checks = 0;
    int passes = 0;

    // Reference model: each slot remembers the full branch address it learned from.
    bit           m_valid [N];
    logic [W-1:0] m_pc    [N];
    logic [W-1:0] m_tgt   [N];
    int           m_ctr   [N];

    hazard3_branch_predictor #(.W_ADDR(W), .N_ENTRIES(N)) dut (
        .clk(clk), .rst(rst),
        .pred_vld(pred_vld), .pred_pc(pred_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .inval(inval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slot(input logic [W-1:0] pc);
        return int'((pc / 2) % N);
    endfunction

    function automatic bit same_branch(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a / (2 ** (K + 1))) == (b / (2 ** (K + 1)));
    endfunction

    // Expected {hit, taken, target} for a lookup against current model state.
    function automatic logic [W+1:0] mdl_expect(input logic vld, input logic [W-1:0] pc);
        int  s;
        bit  h;
        s = slot(pc);
        h = vld && m_valid[s] && same_branch(m_pc[s], pc);
        if (!h) return '0;
        return {1'b1, (m_ctr[s] >= 2) ? 1'b1 : 1'b0, m_tgt[s]};
    endfunction

    function automatic void mdl_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
    endfunction

    function automatic void mdl_train(input logic v, input logic [W-1:0] pc, input logic tk,
                                      input logic [W-1:0] tgt, input logic inv);
        int s;
        s = slot(pc);
        if (inv) begin
            mdl_clear();
        end else if (v) begin
            if (m_valid[s] && same_branch(m_pc[s], pc)) begin
                if (tk) begin
                    m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                    m_tgt[s] = tgt & ~32'h1;
                end else begin
                    m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                end
            end else if (tk) begin
                m_valid[s] = 1;
                m_pc[s]    = pc;
                m_tgt[s]   = tgt & ~32'h1;
                m_ctr[s]   = 2;
            end
        end
    endfunction

    // One training cycle: present inputs, take the edge, mirror it in the model, drop inputs.
    task automatic train(input logic [W-1:0] pc, input logic tk, input logic [W-1:0] tgt,
                         input logic inv);
        upd_vld = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; inval = inv;
        @(posedge clk);
        mdl_train(1'b1, pc, tk, tgt, inv);
        #1;
        upd_vld = 1'b0; inval = 1'b0;
    endtask

    task automatic lookup(input logic [W-1:0] pc);
        pred_vld = 1'b1; pred_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        lookup(32'h100);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== 34'h0)
            $display("FAIL reset_held got=%h want=0", {pred_hit, pred_taken, pred_target});
        else passes++;
        @(negedge clk); rst = 1'b0;
        lookup(32'h100);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== mdl_expect(1'b1, 32'h100))
            $display("FAIL reset_released got=%h want=%h", {pred_hit, pred_taken, pred_target}, mdl_expect(1'b1, 32'h100));
        else passes++;
    endtask

    task automatic test_allocate();
        logic [W+1:0] exp;
        @(posedge clk); #1;
        upd_vld = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80;
        lookup(32'h100);
        exp = mdl_expect(1'b1, 32'h100);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp || exp !== 34'h0)
            $display("FAIL alloc_same_cycle got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
        @(posedge clk);
        mdl_train(1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
        #1; upd_vld = 1'b0;
        lookup(32'h100);
        exp = mdl_expect(1'b1, 32'h100);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp || exp !== {2'b11, 32'h80})
            $display("FAIL alloc_next_cycle got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
    endtask

    task automatic test_decrement();
        logic [W+1:0] exp;
        for (int i = 0; i < 3; i++) begin
            train(32'h100, 1'b0, 32'hDEAD_BEE0, 1'b0);
            lookup(32'h100);
            exp = mdl_expect(1'b1, 32'h100);
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== exp || exp !== {2'b10, 32'h80})
                $display("FAIL dec_step%0d got=%h want=%h", i, {pred_hit, pred_taken, pred_target}, exp);
            else passes++;
        end
        train(32'h200, 1'b0, 32'h44, 1'b0);
        lookup(32'h200);
        exp = mdl_expect(1'b1, 32'h200);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp)
            $display("FAIL nt_miss_no_alloc got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
    endtask

    task automatic test_saturate();
        logic [W+1:0] exp;
        for (int i = 0; i < 4; i++) train(32'h100, 1'b1, 32'h80, 1'b0);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        lookup(32'h100);
        exp = mdl_expect(1'b1, 32'h100);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp || exp !== {2'b11, 32'h80})
            $display("FAIL sat_then_dec got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
        train(32'h100, 1'b0, 32'h0, 1'b0);
        lookup(32'h100);
        exp = mdl_expect(1'b1, 32'h100);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp)
            $display("FAIL sat_dec_twice got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
        train(32'h100, 1'b1, 32'h301, 1'b0);
        lookup(32'h100);
        exp = mdl_expect(1'b1, 32'h100);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp || exp[W-1:0] !== 32'h300)
            $display("FAIL target_retrain got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
    endtask

    task automatic test_alias();
        logic [W+1:0] exp;
        train(32'h100, 1'b1, 32'h80, 1'b0);
        train(32'h108, 1'b1, 32'h40, 1'b0);
        lookup(32'h100);
        exp = mdl_expect(1'b1, 32'h100);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp || exp !== 34'h0)
            $display("FAIL alias_evicted got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
        lookup(32'h108);
        exp = mdl_expect(1'b1, 32'h108);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp || exp !== {2'b11, 32'h40})
            $display("FAIL alias_new got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
    endtask

    task automatic test_inval();
        logic [W+1:0] exp;
        logic [W-1:0] pcs [3];
        pcs = '{32'h100, 32'h102, 32'h104};
        train(32'h100, 1'b1, 32'h80, 1'b0);
        train(32'h102, 1'b1, 32'h90, 1'b0);
        lookup(32'h102);
        exp = mdl_expect(1'b1, 32'h102);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp || exp[W+1] !== 1'b1)
            $display("FAIL inval_pretrain got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
        train(32'h104, 1'b1, 32'h500, 1'b1);
        for (int i = 0; i < 3; i++) begin
            lookup(pcs[i]);
            exp = mdl_expect(1'b1, pcs[i]);
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== exp || exp !== 34'h0)
                $display("FAIL inval_pc%0d got=%h want=%h", i, {pred_hit, pred_taken, pred_target}, exp);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [W+1:0] exp;
        logic         v, tk, inv;
        logic [W-1:0] pc, tgt;
        int           errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            v   = ($urandom_range(0, 2) != 0);
            tk  = $urandom_range(0, 1);
            inv = ($urandom_range(0, 24) == 0);
            pc  = 32'h100 + 32'($urandom_range(0, 15) * 2) + 32'($urandom_range(0, 1));
            tgt = $urandom;
            upd_vld = v; upd_pc = pc; upd_taken = tk; upd_target = tgt; inval = inv;
            pred_vld = ($urandom_range(0, 9) != 0);
            pred_pc  = 32'h100 + 32'($urandom_range(0, 15) * 2) + 32'($urandom_range(0, 1));
            #1;
            exp = mdl_expect(pred_vld, pred_pc);
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== exp) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random_c%0d pc=%h got=%h want=%h", c, pred_pc, {pred_hit, pred_taken, pred_target}, exp);
            end else passes++;
            @(posedge clk);
            mdl_train(v, pc, tk, tgt, inv);
            #1;
        end
        upd_vld = 1'b0; inval = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [W+1:0] exp;
        train(32'h100, 1'b1, 32'h80, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        mdl_clear();
        lookup(32'h100);
        exp = mdl_expect(1'b1, 32'h100);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp || exp !== 34'h0)
            $display("FAIL async_reset got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
        // A taken update held across reset must not survive its release.
        upd_vld = 1'b1; upd_pc = 32'h104; upd_taken = 1'b1; upd_target = 32'h600;
        @(posedge clk); #2;
        rst = 1'b0;
        upd_vld = 1'b0;
        lookup(32'h104);
        exp = mdl_expect(1'b1, 32'h104);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== exp || exp !== 34'h0)
            $display("FAIL reset_drops_update got=%h want=%h", {pred_hit, pred_taken, pred_target}, exp);
        else passes++;
    endtask

    initial begin
        rst = 1'b1; pred_vld = 1'b0; pred_pc = '0;
        upd_vld = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; inval = 1'b0;
        mdl_clear();
        for (int i = 0; i < N; i++) begin
            m_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        #12;
        test_reset();
        test_allocate();
        test_decrement();
        test_saturate();
        test_alias();
        test_inval();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
